mac_r_rx_cond: RTL and testbench

- Receive-side PHY conditioner between the GMII/MII PHY pins and the receive MAC (`mac_r_gmii`) in the rx_clk domain.
- Registers the raw `phy_rx_dv`/`phy_rx_er`/`phy_rxd` and enforces minimum inter-frame gap.
- Truncates jabber frames and poisons `rx_er` frames so the downstream CRC check fails.
- Keeps saturating per-event statistics counters.

---
 rtl/mac_r_rx_cond.sv | 194 +++++++++++++++++++
 tb/tb_mac_r_rx_cond.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_r_rx_cond.sv
// mac_r_rx_cond -- receive-side PHY conditioner (rx_clk domain)
//
// Sits between the GMII/MII PHY pins and the receive MAC. It registers the
// raw receive pins, drops frames that start too soon after the previous one
// (short inter-frame gap), truncates jabber frames, poisons bytes received
// with rx_er so the downstream CRC check fails, and keeps saturating
// per-event statistics counters.
//
// Ports
//   rx_clk, rstn          PHY receive clock, asynchronous active-low reset
//   speed[1:0]            00:10M 01:100M 10:1000M (speed[1]=1 -> byte mode)
//   phy_rx_dv/er, phy_rxd raw PHY receive pins
//   rx_dv, gm_rx_d        conditioned data valid / data to the MAC (1 cycle late)
//   clr_cnt               synchronous clear of all counters (wins over increments)
//   cnt_ok, cnt_err, cnt_jabber, cnt_ifg_drop, cnt_false_car
//                         saturating event counters, CNT_W bits each
//
// Parameters: MIN_IFG (byte times, >=1), MAX_BYTES (<8192), CNT_W.

module mac_r_rx_cond #(
    parameter int MIN_IFG   = 12,
    parameter int MAX_BYTES = 1530,
    parameter int CNT_W     = 16
) (
    input  logic             rx_clk,
    input  logic             rstn,
    input  logic [1:0]       speed,
    input  logic             phy_rx_dv,
    input  logic             phy_rx_er,
    input  logic [7:0]       phy_rxd,
    output logic             rx_dv,
    output logic [7:0]       gm_rx_d,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err,
    output logic [CNT_W-1:0] cnt_jabber,
    output logic [CNT_W-1:0] cnt_ifg_drop,
    output logic [CNT_W-1:0] cnt_false_car
);

    localparam int GAP_W = $clog2(MIN_IFG + 1);

    // counter slots
    localparam int C_OK  = 0;
    localparam int C_ERR = 1;
    localparam int C_JAB = 2;
    localparam int C_IFG = 3;
    localparam int C_FC  = 4;
    localparam int N_CNT = 5;

    typedef enum logic [1:0] {IDLE, PASS, DROP, TRUNC} state_t;

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [12:0]        len_q, len_d;
    logic               err_q, err_d;
    logic               byte_q, byte_d;     // speed[1] latched at frame start
    logic               fc_q, fc_d;         // false carrier already counted for this er pulse
    logic               dv_prev_q;
    logic               ph_q;               // nibble phase: 1 = second half of a byte time
    logic               rx_dv_q, rx_dv_d;
    logic [7:0]         gm_rx_d_q, gm_rx_d_d;
    logic [CNT_W-1:0]   cnt_q [N_CNT];
    logic [N_CNT-1:0]   cnt_inc;

    logic       dv_rise, dv_edge, byte_mode, tick, fc_code;
    logic [7:0] fwd_data;
    logic       speed_unused;

    // speed[0] only distinguishes 10M from 100M, which look identical here
    assign speed_unused = speed[0];

    assign dv_rise  = phy_rx_dv & ~dv_prev_q;
    assign dv_edge  = phy_rx_dv ^ dv_prev_q;
    // Idle time follows the live speed pins; inside a frame the speed is frozen.
    assign byte_mode = (state_q == IDLE) ? speed[1] : byte_q;
    // Nibble mode: one byte time per two cycles, phase restarted on every dv edge.
    assign tick     = byte_mode | (~dv_edge & ph_q);
    assign fwd_data = phy_rx_er ? ~phy_rxd : phy_rxd;
    assign fc_code  = speed[1] ? (phy_rxd == 8'h0E) : (phy_rxd[3:0] == 4'hE);

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        len_d     = len_q;
        err_d     = err_q;
        byte_d    = byte_q;
        fc_d      = fc_q & phy_rx_er;
        rx_dv_d   = 1'b0;
        gm_rx_d_d = 8'h00;
        cnt_inc   = '0;
        case (state_q)
            IDLE: begin
                if (phy_rx_dv) begin
                    byte_d = speed[1];
                    // dv high without a rise only happens right after reset
                    // mid-frame; that partial frame is discarded silently.
                    if (dv_rise && gap_q >= GAP_W'(MIN_IFG)) begin
                        state_d   = PASS;
                        len_d     = {12'd0, tick};
                        err_d     = phy_rx_er;
                        rx_dv_d   = 1'b1;
                        gm_rx_d_d = fwd_data;
                    end else begin
                        state_d        = DROP;
                        cnt_inc[C_IFG] = dv_rise;
                    end
                end else begin
                    if (tick && gap_q < GAP_W'(MIN_IFG)) begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                    if (phy_rx_er && fc_code && !fc_q) begin
                        cnt_inc[C_FC] = 1'b1;
                        fc_d          = 1'b1;
                    end
                end
            end
            PASS: begin
                if (!phy_rx_dv) begin
                    // the fall cycle is the first idle byte time of the gap
                    state_d = IDLE;
                    gap_d   = GAP_W'(tick);
                    if (err_q || phy_rx_er) cnt_inc[C_ERR] = 1'b1;
                    else                    cnt_inc[C_OK]  = 1'b1;
                end else if (len_q >= 13'(MAX_BYTES)) begin
                    state_d        = TRUNC;
                    cnt_inc[C_JAB] = 1'b1;
                end else begin
                    rx_dv_d   = 1'b1;
                    gm_rx_d_d = fwd_data;
                    len_d     = len_q + {12'd0, tick};
                    if (phy_rx_er) err_d = 1'b1;
                end
            end
            DROP, TRUNC: begin
                if (!phy_rx_dv) begin
                    state_d = IDLE;
                    gap_d   = GAP_W'(tick);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            gap_q     <= GAP_W'(MIN_IFG);
            len_q     <= '0;
            err_q     <= 1'b0;
            byte_q    <= 1'b1;
            fc_q      <= 1'b0;
            // Pretend dv was high so a frame already in progress at reset
            // release is not mistaken for a fresh start of frame.
            dv_prev_q <= 1'b1;
            ph_q      <= 1'b0;
            rx_dv_q   <= 1'b0;
            gm_rx_d_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            len_q     <= len_d;
            err_q     <= err_d;
            byte_q    <= byte_d;
            fc_q      <= fc_d;
            dv_prev_q <= phy_rx_dv;
            ph_q      <= dv_edge | ~ph_q;
            rx_dv_q   <= rx_dv_d;
            gm_rx_d_q <= gm_rx_d_d;
        end
    end

    // saturating statistics counters; clear beats a same-cycle increment
    for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
        always_ff @(posedge rx_clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q[gi] <= '0;
            end else if (clr_cnt) begin
                cnt_q[gi] <= '0;
            end else if (cnt_inc[gi] && cnt_q[gi] != '1) begin
                cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
            end
        end
    end

    assign rx_dv         = rx_dv_q;
    assign gm_rx_d       = gm_rx_d_q;
    assign cnt_ok        = cnt_q[C_OK];
    assign cnt_err       = cnt_q[C_ERR];
    assign cnt_jabber    = cnt_q[C_JAB];
    assign cnt_ifg_drop  = cnt_q[C_IFG];
    assign cnt_false_car = cnt_q[C_FC];

endmodule

// File: tb/tb_mac_r_rx_cond.sv
// Testbench for mac_r_rx_cond. Frames are described by length, data, per-byte
// rx_er and preceding idle gap; the expected output stream and counters are
// derived from those frame descriptions with plain arithmetic. Counters are
// narrowed so saturation is reachable in a short run.

module tb_mac_r_rx_cond;

    localparam int MIN_IFG   = 12;
    localparam int MAX_BYTES = 1530;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             rx_clk = 1'b0;
    logic             rstn;
    logic [1:0]       speed;
    logic             phy_rx_dv, phy_rx_er;
    logic [7:0]       phy_rxd;
    logic             rx_dv;
    logic [7:0]       gm_rx_d;
    logic             clr_cnt;
    logic [CNT_W-1:0] cnt_ok, cnt_err, cnt_jabber, cnt_ifg_drop, cnt_false_car;

    mac_r_rx_cond #(
        .MIN_IFG   (MIN_IFG),
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .rx_clk        (rx_clk),
        .rstn          (rstn),
        .speed         (speed),
        .phy_rx_dv     (phy_rx_dv),
        .phy_rx_er     (phy_rx_er),
        .phy_rxd       (phy_rxd),
        .rx_dv         (rx_dv),
        .gm_rx_d       (gm_rx_d),
        .clr_cnt       (clr_cnt),
        .cnt_ok        (cnt_ok),
        .cnt_err       (cnt_err),
        .cnt_jabber    (cnt_jabber),
        .cnt_ifg_drop  (cnt_ifg_drop),
        .cnt_false_car (cnt_false_car)
    );

    always #5 rx_clk = ~rx_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int exp_ok, exp_err, exp_jab, exp_ifg, exp_fc;
    int gap_cycles;
    logic [7:0] fd  [0:1999];
    bit         fer [0:1999];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic zero_model();
        exp_ok = 0; exp_err = 0; exp_jab = 0; exp_ifg = 0; exp_fc = 0;
    endtask

    task automatic check_counters(input string where);
        check({where, "/cnt_ok"},        32'(cnt_ok),        32'(sat(exp_ok)));
        check({where, "/cnt_err"},       32'(cnt_err),       32'(sat(exp_err)));
        check({where, "/cnt_jabber"},    32'(cnt_jabber),    32'(sat(exp_jab)));
        check({where, "/cnt_ifg_drop"},  32'(cnt_ifg_drop),  32'(sat(exp_ifg)));
        check({where, "/cnt_false_car"}, 32'(cnt_false_car), 32'(sat(exp_fc)));
    endtask

    // One clock: apply inputs, then look at the registered outputs just after the edge.
    task automatic drive(input logic dv, input logic er, input logic [7:0] d,
                         input logic e_dv, input logic [7:0] e_d);
        phy_rx_dv = dv;
        phy_rx_er = er;
        phy_rxd   = d;
        @(posedge rx_clk);
        #1;
        check("rx_dv",   32'(rx_dv),   32'(e_dv));
        check("gm_rx_d", 32'(gm_rx_d), 32'(e_d));
    endtask

    task automatic run_gap(input int n, input bit clr_first);
        for (int i = 0; i < n; i++) begin
            clr_cnt = clr_first && (i == 0);
            drive(1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00);
        end
        clr_cnt = 1'b0;
        gap_cycles += n;
        if (clr_first) zero_model();
        check_counters("gap");
    endtask

    task automatic fill(input int len, input int er_rate);
        for (int i = 0; i < len; i++) begin
            fd[i]  = 8'($urandom);
            fer[i] = (er_rate != 0) && ($urandom_range(er_rate - 1, 0) == 0);
        end
    endtask

    // Frame acceptance is decided by the gap in byte times, output is capped
    // at MAX_BYTES byte times, and the frame lands in exactly one counter.
    task automatic send_frame(input int len);
        bit         byte_mode, accept, any_er, e_dv;
        int         bt, limit;
        logic [7:0] e_d;
        byte_mode = speed[1];
        bt        = byte_mode ? gap_cycles : gap_cycles / 2;
        accept    = (bt >= MIN_IFG);
        limit     = byte_mode ? MAX_BYTES : 2 * MAX_BYTES;
        any_er    = 1'b0;
        for (int i = 0; i < len; i++) begin
            e_dv = accept && (i < limit);
            e_d  = e_dv ? (fer[i] ? ~fd[i] : fd[i]) : 8'h00;
            if (e_dv && fer[i]) any_er = 1'b1;
            drive(1'b1, fer[i], fd[i], e_dv, e_d);
        end
        if (!accept)         exp_ifg++;
        else if (len > limit) exp_jab++;
        else if (any_er)     exp_err++;
        else                 exp_ok++;
        gap_cycles = 0;
    endtask

    task automatic false_carrier(input int k, input logic [7:0] d);
        bit hit;
        hit = speed[1] ? (d == 8'h0E) : (d[3:0] == 4'hE);
        for (int i = 0; i < k; i++) drive(1'b0, 1'b1, d, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        if (hit && k > 0) exp_fc++;
        gap_cycles += k + 1;
        check_counters("fcar");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        speed = 2'b10; phy_rx_dv = 0; phy_rx_er = 0; phy_rxd = 8'h00; clr_cnt = 0;
        rstn = 1'b0;
        zero_model();
        gap_cycles = 1000;
        repeat (3) @(posedge rx_clk);
        #1;
        check("reset/rx_dv",   32'(rx_dv),   32'd0);
        check("reset/gm_rx_d", 32'(gm_rx_d), 32'd0);
        check_counters("reset");
        rstn = 1'b1;
        run_gap(2, 0);

        // byte mode: 72-byte frame, then short (8) and legal (12) gaps
        fill(72, 0);  send_frame(72);  run_gap(8, 0);
        fill(60, 0);  send_frame(60);  run_gap(12, 0);
        fill(60, 0);  send_frame(60);  run_gap(12, 0);

        // rx_er on byte 30 poisons that byte
        fill(64, 0); fd[30] = 8'h5A; fer[30] = 1'b1;
        send_frame(64); run_gap(12, 0);

        // jabber, then a frame after a 12-cycle gap
        fill(1600, 0); send_frame(1600); run_gap(12, 0);
        fill(50, 0);   send_frame(50);   run_gap(20, 0);

        // nibble mode: 20-cycle gap is 10 byte times, 24 is 12
        speed = 2'b01; run_gap(30, 0);
        fill(144, 0); send_frame(144); run_gap(20, 0);
        fill(144, 0); send_frame(144); run_gap(24, 0);
        fill(144, 0); send_frame(144); run_gap(24, 0);
        false_carrier(3, 8'h3E);

        // byte-mode false carrier
        speed = 2'b10; run_gap(30, 0);
        false_carrier(3, 8'h0E);
        false_carrier(2, 8'h3E);
        false_carrier(1, 8'h0F);

        // randomized byte-mode traffic around the gap boundary
        for (int f = 0; f < 180; f++) begin
            int len;
            len = $urandom_range(120, 1);
            fill(len, 40);
            send_frame(len);
            run_gap($urandom_range(16, 6), 0);
        end

        // push cnt_ok past saturation
        guard = 0;
        while (exp_ok <= CNT_MAX + 2 && guard < 200) begin
            fill(4, 0); send_frame(4); run_gap(12, 0);
            guard++;
        end

        // randomized nibble-mode traffic
        speed = 2'b01; run_gap(30, 0);
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(80, 1);
            fill(len, 30);
            send_frame(len);
            run_gap($urandom_range(30, 16), 0);
        end

        // clr_cnt on the same cycle as the cnt_ok increment
        speed = 2'b10; run_gap(30, 0);
        fill(20, 0); send_frame(20); run_gap(12, 1);
        fill(20, 0); send_frame(20); run_gap(12, 0);

        // reset in the middle of a frame
        fill(40, 0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, fd[i], 1'b1, fd[i]);
        rstn = 1'b0;
        #1;
        check("rst_mid/rx_dv",   32'(rx_dv),   32'd0);
        check("rst_mid/gm_rx_d", 32'(gm_rx_d), 32'd0);
        check("rst_mid/cnt_ok",  32'(cnt_ok),  32'd0);
        @(posedge rx_clk);
        #1;
        rstn = 1'b1;
        zero_model();
        for (int i = 10; i < 40; i++) drive(1'b1, 1'b0, fd[i], 1'b0, 8'h00);
        gap_cycles = 0;
        run_gap(12, 0);
        fill(30, 0); send_frame(30); run_gap(12, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
